// File: rtl/jtsdram_ledctl_pkg.sv
// Shared constants and types for the SDRAM status LED controller.
// The sequencer state encoding and the gap multiplier live here so that
// the top level, the blink sequencer and any checkers agree on them.
package jtsdram_ledctl_pkg;

   // Error-code sequencer states
   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_ON   = 2'd1,
      SEQ_OFF  = 2'd2,
      SEQ_GAP  = 2'd3
   } seq_state_t;

   // The gap between code repetitions lasts this many PULSE periods
   localparam int GAP_MULT = 4;

   // Width of the error code: up to 8 channels -> codes 1..8
   localparam int CODE_W = 4;

endpackage

// File: rtl/jtsdram_blinkseq.sv
// Error-code blink sequencer. On a frame tick in IDLE it latches the code
// and blinks code_led that many times (PULSE frames on, PULSE frames off),
// then stays dark for GAP_MULT*PULSE frames before re-sampling.
// Dropping err_any aborts to IDLE on the next edge from any state.
module jtsdram_blinkseq
   import jtsdram_ledctl_pkg::*;
#(
   parameter int PULSE = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              err_any,
   input  logic [CODE_W-1:0] code,
   output logic              code_led
);

   localparam int PH_W = $clog2(GAP_MULT * PULSE);
   localparam logic [PH_W-1:0] PH_PULSE_END = PH_W'(PULSE - 1);
   localparam logic [PH_W-1:0] PH_GAP_END   = PH_W'(GAP_MULT * PULSE - 1);

   seq_state_t         state_q;
   logic [PH_W-1:0]    phase_q;
   logic [CODE_W-1:0]  blink_q;
   logic               code_led_q;

   assign code_led = code_led_q;

   // Sequencer: phase counts ticks spent in the current state and is
   // cleared on every state entry; code_led is registered from the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= SEQ_IDLE;
         phase_q    <= '0;
         blink_q    <= '0;
         code_led_q <= 1'b0;
      end else if (!err_any) begin
         state_q    <= SEQ_IDLE;
         phase_q    <= '0;
         blink_q    <= '0;
         code_led_q <= 1'b0;
      end else if (tick) begin
         case (state_q)
            SEQ_IDLE: begin
               blink_q    <= code;
               phase_q    <= '0;
               state_q    <= SEQ_ON;
               code_led_q <= 1'b1;
            end
            SEQ_ON: begin
               if (phase_q == PH_PULSE_END) begin
                  blink_q    <= blink_q - CODE_W'(1);
                  phase_q    <= '0;
                  state_q    <= SEQ_OFF;
                  code_led_q <= 1'b0;
               end else begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            SEQ_OFF: begin
               if (phase_q == PH_PULSE_END) begin
                  phase_q <= '0;
                  if (blink_q != '0) begin
                     state_q    <= SEQ_ON;
                     code_led_q <= 1'b1;
                  end else begin
                     state_q    <= SEQ_GAP;
                     code_led_q <= 1'b0;
                  end
               end else begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            SEQ_GAP: begin
               if (phase_q == PH_GAP_END) begin
                  phase_q    <= '0;
                  state_q    <= SEQ_IDLE;
                  code_led_q <= 1'b0;
               end else begin
                  phase_q <= phase_q + PH_W'(1);
               end
            end
            default: begin
               phase_q    <= '0;
               state_q    <= SEQ_IDLE;
               code_led_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/jtsdram_ledctl.sv
// SDRAM status LED controller. Frame ticks come from the rising edge of
// LVBL; a free-running frame counter makes the channel LEDs blink slowly
// for channels with a sticky error and fast for healthy ones. The lowest
// failing channel number is also blinked out on code_led.
module jtsdram_ledctl
   import jtsdram_ledctl_pkg::*;
#(
   parameter int CH    = 4,
   parameter int CW    = 5,
   parameter int PULSE = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          LVBL,
   input  logic [CH-1:0] bad,
   input  logic          clr,
   output logic [CH-1:0] led,
   output logic          code_led,
   output logic          err_any
);

   logic              last_lvbl_q;
   logic              tick;
   logic [CW-1:0]     cnt_q;
   logic [CH-1:0]     sticky_q;
   logic [CH-1:0]     sticky_d;
   logic [CH-1:0]     led_q;
   logic              err_any_q;
   logic [CODE_W-1:0] code_d;

   assign tick    = LVBL & ~last_lvbl_q;
   assign led     = led_q;
   assign err_any = err_any_q;

   // A new error always wins over a simultaneous clear
   always_comb begin
      sticky_d = bad | (sticky_q & ~{CH{clr}});
   end

   // Code is the 1-based index of the lowest failing channel
   always_comb begin
      code_d = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (sticky_q[i]) code_d = CODE_W'(i + 1);
      end
   end

   // Frame edge detect, frame counter, sticky errors and LED vector.
   // last_lvbl resets high so LVBL held high through reset gives no tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_lvbl_q <= 1'b1;
         cnt_q       <= '0;
         sticky_q    <= '0;
         led_q       <= '0;
         err_any_q   <= 1'b0;
      end else begin
         last_lvbl_q <= LVBL;
         if (tick) cnt_q <= cnt_q + CW'(1);
         sticky_q  <= sticky_d;
         err_any_q <= |sticky_d;
         for (int i = 0; i < CH; i++) begin
            led_q[i] <= sticky_q[i] ? cnt_q[CW-1] : cnt_q[0];
         end
      end
   end

   jtsdram_blinkseq #(
      .PULSE (PULSE)
   ) u_seq (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .err_any  (err_any_q),
      .code     (code_d),
      .code_led (code_led)
   );

endmodule

// File: tb/tb_jtsdram_ledctl.sv
// Bench for jtsdram_ledctl with CH=4, CW=5, PULSE=2.
module tb_jtsdram_ledctl;

   logic       clk;
   logic       rst;
   logic       LVBL;
   logic [3:0] bad;
   logic       clr;
   logic [3:0] led;
   logic       code_led;
   logic       err_any;

   int n_vec;
   int n_err;
   int tb_cnt;

   typedef struct {
      logic       rst;
      logic       lvbl;
      logic [3:0] bad;
      logic       clr;
      logic [3:0] led;
      logic       code_led;
      logic       err_any;
   } vec_t;

   vec_t vecs[15];

   jtsdram_ledctl #(
      .CH    (4),
      .CW    (5),
      .PULSE (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .LVBL     (LVBL),
      .bad      (bad),
      .clr      (clr),
      .led      (led),
      .code_led (code_led),
      .err_any  (err_any)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one frame: LVBL low for one edge, then high (tick on the second edge)
   task automatic frame();
      LVBL = 1'b0;
      step();
      LVBL = 1'b1;
      step();
      tb_cnt = (tb_cnt + 1) % 32;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] led_exp(input logic [3:0] st, input int c);
      logic [4:0] cv;
      logic [3:0] r;
      cv = 5'(c);
      for (int i = 0; i < 4; i++) r[i] = st[i] ? cv[4] : cv[0];
      return r;
   endfunction

   logic [21:0] pat3;
   logic [24:0] pat2;

   initial begin
      n_vec = 0;
      n_err = 0;
      tb_cnt = 0;
      rst = 1'b1;
      LVBL = 1'b1;
      bad = 4'h0;
      clr = 1'b0;

      //          rst   lvbl  bad   clr   led   cled  err
      vecs[0]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 4'h4, 1'b0, 4'hF, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'hB, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 4'h4, 1'b1, 4'hB, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 4'h0, 1'b0, 4'hB, 1'b0, 1'b1};

      // reset, release with LVBL high, three frames, first error
      for (int k = 0; k < 15; k++) begin
         rst  = vecs[k].rst;
         LVBL = vecs[k].lvbl;
         bad  = vecs[k].bad;
         clr  = vecs[k].clr;
         step();
         check($sformatf("vec%0d_led", k), {4'h0, led}, {4'h0, vecs[k].led});
         check($sformatf("vec%0d_code_led", k), {7'h0, code_led}, {7'h0, vecs[k].code_led});
         check($sformatf("vec%0d_err_any", k), {7'h0, err_any}, {7'h0, vecs[k].err_any});
      end
      bad = 4'h0;
      clr = 1'b0;
      tb_cnt = 3;

      // code 3: on 2 / off 2 three times, dark through gap and idle, repeat
      pat3 = 22'b1100110011000000000001;
      for (int t = 0; t < 22; t++) begin
         frame();
         check($sformatf("code3_tick%0d", t + 1), {7'h0, code_led}, {7'h0, pat3[21 - t]});
      end

      // frame counter wrap seen through led[2]=cnt[4], others cnt[0]
      while (tb_cnt != 31) frame();
      step();
      check("cnt31_led", {4'h0, led}, 8'h0F);
      frame();
      step();
      check("cnt_wrap0_led", {4'h0, led}, 8'h00);
      while (tb_cnt != 16) frame();
      step();
      check("cnt16_led", {4'h0, led}, 8'h04);

      // clear everything, back to idle
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();
      step();
      check("clr_all_err_any", {7'h0, err_any}, 8'h00);
      check("clr_all_code_led", {7'h0, code_led}, 8'h00);

      // code 2 latched; bad[0] during second ON only affects next sequence
      bad = 4'hA;
      step();
      bad = 4'h0;
      step();
      pat2 = 25'b1100110000000000011000000;
      for (int t = 0; t < 25; t++) begin
         if (t == 5) bad = 4'h1;
         frame();
         bad = 4'h0;
         check($sformatf("code2_tick%0d", t + 1), {7'h0, code_led}, {7'h0, pat2[24 - t]});
      end

      // clr together with bad[1]: bit 1 survives
      clr = 1'b1;
      bad = 4'h2;
      step();
      check("clr_setwins_err_any", {7'h0, err_any}, 8'h01);
      clr = 1'b0;
      bad = 4'h0;
      step();
      check("clr_setwins_led", {4'h0, led}, {4'h0, led_exp(4'h2, tb_cnt)});

      // clear with nothing pending
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_err_any", {7'h0, err_any}, 8'h00);
      step();
      check("clr_code_led", {7'h0, code_led}, 8'h00);

      // clear during ON aborts the sequence
      bad = 4'h2;
      step();
      bad = 4'h0;
      step();
      frame();
      check("on_before_abort", {7'h0, code_led}, 8'h01);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("abort_err_any", {7'h0, err_any}, 8'h00);
      check("abort_code_led_hold", {7'h0, code_led}, 8'h01);
      step();
      check("abort_code_led", {7'h0, code_led}, 8'h00);
      for (int t = 0; t < 2; t++) begin
         frame();
         check($sformatf("after_abort_code_led%0d", t), {7'h0, code_led}, 8'h00);
         check($sformatf("after_abort_err_any%0d", t), {7'h0, err_any}, 8'h00);
      end
      // state was IDLE: the first tick with an error starts ON
      bad = 4'h2;
      step();
      bad = 4'h0;
      step();
      frame();
      check("restart_on1", {7'h0, code_led}, 8'h01);
      frame();
      check("restart_on2", {7'h0, code_led}, 8'h01);
      frame();
      check("restart_off", {7'h0, code_led}, 8'h00);

      // reset during OFF, with bad asserted to show reset priority
      rst = 1'b1;
      bad = 4'h2;
      step();
      check("rst_led", {4'h0, led}, 8'h00);
      check("rst_code_led", {7'h0, code_led}, 8'h00);
      check("rst_err_any", {7'h0, err_any}, 8'h00);
      rst = 1'b0;
      bad = 4'h0;
      tb_cnt = 0;
      for (int t = 0; t < 3; t++) begin
         step();
         check($sformatf("post_rst_led%0d", t), {4'h0, led}, 8'h00);
         check($sformatf("post_rst_err%0d", t), {7'h0, err_any}, 8'h00);
      end
      frame();
      step();
      check("post_rst_first_tick_led", {4'h0, led}, 8'h0F);
      check("post_rst_code_led", {7'h0, code_led}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
